// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and frame geometry.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   localparam int UART_FRAME_BITS = 10;
   localparam int UART_DATA_BITS  = 8;
   localparam int UART_MIN_DIV    = 2;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO feeding the UART shifter; head entry is visible on data_o
// so the FSM can load it on the same edge that pops it.
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic [LW-1:0]    level_d;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q];
   assign level_o = level_q;

   always_comb begin
      level_d = level_q;
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // Storage has no reset; the pointers and level define what is valid.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q <= level_d;
      end
   end

endmodule

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter: byte FIFO ahead of a start/data/stop shifter with a per-frame
// latched bit period, so clk_div changes only take effect on the next frame.
module uart_tx_core
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                          wb_clk_i,
   input  logic                          wb_rst_i,
   input  logic [DIV_WIDTH-1:0]          clk_div,
   input  logic                          tx_en,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          ser_tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int LW       = $clog2(FIFO_DEPTH) + 1;
   localparam int IDX_W    = $clog2(UART_DATA_BITS);
   localparam int LAST_IDX = UART_FRAME_BITS - 3;  // frame minus start, stop, and zero-based

   logic                      fifo_full;
   logic                      fifo_empty;
   logic                      fifo_pop;
   logic                      push;
   logic [UART_DATA_BITS-1:0] fifo_data;

   uart_state_e               state_q;
   logic [DIV_WIDTH-1:0]      cnt_q;
   logic [DIV_WIDTH-1:0]      div_q;
   logic [DIV_WIDTH-1:0]      div_eff;
   logic [IDX_W-1:0]          bit_idx_q;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic                      ser_q;
   logic                      busy_q;
   logic                      busy_d;
   logic                      bit_done;
   logic                      start_frame;
   logic                      active_d;
   logic                      nonempty_d;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .clk_i   (wb_clk_i),
      .rst_i   (wb_rst_i),
      .push_i  (push),
      .data_i  (tx_data),
      .pop_i   (fifo_pop),
      .data_o  (fifo_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   assign tx_ready    = !fifo_full;
   assign push        = tx_valid && !fifo_full;
   assign div_eff     = (clk_div < DIV_WIDTH'(UART_MIN_DIV)) ? DIV_WIDTH'(UART_MIN_DIV) : clk_div;
   assign bit_done    = (cnt_q == div_q - DIV_WIDTH'(1));
   // A new frame may start from IDLE or straight out of a finishing stop bit.
   assign start_frame = tx_en && !fifo_empty &&
                        ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_done));
   assign fifo_pop    = start_frame;
   assign active_d    = start_frame ||
                        ((state_q != ST_IDLE) && !((state_q == ST_STOP) && bit_done));
   assign nonempty_d  = push || (fifo_level > LW'(1)) || ((fifo_level == LW'(1)) && !fifo_pop);
   assign busy_d      = active_d || nonempty_d;

   assign ser_tx = ser_q;
   assign busy   = busy_q;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         div_q     <= DIV_WIDTH'(UART_MIN_DIV);
         bit_idx_q <= '0;
         shift_q   <= '0;
         ser_q     <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         busy_q <= busy_d;
         if (start_frame) begin
            state_q <= ST_START;
            shift_q <= fifo_data;
            div_q   <= div_eff;
            cnt_q   <= '0;
            ser_q   <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  ser_q <= 1'b1;
               end
               ST_START: begin
                  if (bit_done) begin
                     cnt_q     <= '0;
                     bit_idx_q <= '0;
                     ser_q     <= shift_q[0];
                     state_q   <= ST_DATA;
                  end else begin
                     cnt_q <= cnt_q + DIV_WIDTH'(1);
                  end
               end
               ST_DATA: begin
                  if (bit_done) begin
                     cnt_q   <= '0;
                     shift_q <= shift_q >> 1;
                     if (bit_idx_q == IDX_W'(LAST_IDX)) begin
                        ser_q   <= 1'b1;
                        state_q <= ST_STOP;
                     end else begin
                        bit_idx_q <= bit_idx_q + IDX_W'(1);
                        ser_q     <= shift_q[1];
                     end
                  end else begin
                     cnt_q <= cnt_q + DIV_WIDTH'(1);
                  end
               end
               ST_STOP: begin
                  if (bit_done) begin
                     state_q <= ST_IDLE;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + DIV_WIDTH'(1);
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  ser_q   <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: a line sampler decodes frames at the expected bit period
// while the main sequence drives table vectors and multi-cycle corner cases.
module tb_uart_tx_core;

   logic        clk;
   logic        rst;
   logic [15:0] clk_div;
   logic        tx_en;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        ser_tx;
   logic        busy;
   logic [2:0]  fifo_level;

   int checks   = 0;
   int failures = 0;

   uart_tx_core #(
      .FIFO_DEPTH (4),
      .DIV_WIDTH  (16)
   ) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .clk_div    (clk_div),
      .tx_en      (tx_en),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .ser_tx     (ser_tx),
      .busy       (busy),
      .fifo_level (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test expected finish before 500us");
      $fatal(1, "watchdog");
   end

   // ---------------- line sampler ----------------
   logic [7:0] rx_q [$];
   int         gap_q [$];
   int         mon_div  = 4;
   int         idle_cnt = 1000;
   int         m_d;
   logic       m_ok;
   logic       m_ab;
   logic [9:0] m_fr;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst && ser_tx === 1'b0) begin
            m_d  = mon_div;
            m_ok = 1'b1;
            m_ab = 1'b0;
            m_fr = '0;
            gap_q.push_back(idle_cnt);
            for (int j = 0; j < 10; j++) begin
               for (int k = 0; k < m_d; k++) begin
                  if (j != 0 || k != 0) @(negedge clk);
                  if (rst) m_ab = 1'b1;
                  if (k == 0) m_fr[j] = ser_tx;
                  else if (ser_tx !== m_fr[j]) m_ok = 1'b0;
               end
            end
            if (m_ab) begin
               void'(gap_q.pop_back());
            end else begin
               checks++;
               if (!m_ok || m_fr[0] !== 1'b0 || m_fr[9] !== 1'b1) begin
                  failures++;
                  $display("FAIL frame_format: got %b expected start=0 stop=1 bits steady for %0d clks",
                           m_fr, m_d);
               end
               rx_q.push_back(m_fr[8:1]);
            end
            idle_cnt = 0;
         end else begin
            idle_cnt++;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int rx_at(input int i);
      return (rx_q.size() > i) ? int'(rx_q[i]) : 32'hDEAD;
   endfunction

   function automatic int gap_at(input int i);
      return (gap_q.size() > i) ? gap_q[i] : 999;
   endfunction

   task automatic push(input logic [7:0] b);
      tx_data  = b;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
   endtask

   task automatic wait_rx(input int n, input int budget);
      int c;
      c = 0;
      while (rx_q.size() < n && c < budget) begin
         @(posedge clk);
         c++;
      end
      #1;
      chk("rx_count", rx_q.size(), n);
   endtask

   task automatic clear_rx();
      rx_q.delete();
      gap_q.delete();
   endtask

   typedef struct {
      logic [15:0] div;
      logic [7:0]  data;
      int          div_eff;
      int          exp_level;
   } vec_t;

   vec_t       vecs [6];
   logic [7:0] msg  [3];

   initial begin
      vecs[0] = '{div: 16'd0, data: 8'h3C, div_eff: 2, exp_level: 1};
      vecs[1] = '{div: 16'd1, data: 8'hA5, div_eff: 2, exp_level: 1};
      vecs[2] = '{div: 16'd2, data: 8'h00, div_eff: 2, exp_level: 1};
      vecs[3] = '{div: 16'd3, data: 8'hFF, div_eff: 3, exp_level: 1};
      vecs[4] = '{div: 16'd5, data: 8'h81, div_eff: 5, exp_level: 1};
      vecs[5] = '{div: 16'd7, data: 8'h6E, div_eff: 7, exp_level: 1};
      msg[0] = 8'h41;
      msg[1] = 8'h42;
      msg[2] = 8'h0A;

      rst      = 1'b1;
      tx_en    = 1'b1;
      clk_div  = 16'd4;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_ser_tx", ser_tx, 1);
      chk("reset_tx_ready", tx_ready, 1);
      chk("reset_busy", busy, 0);
      chk("reset_level", fifo_level, 0);

      // Test 1: 0x55 at div 4, exact latency and busy drop
      mon_div = 4;
      clear_rx();
      push(8'h55);
      chk("t1_pre_start_ser", ser_tx, 1);
      chk("t1_level_after_push", fifo_level, 1);
      chk("t1_busy_after_push", busy, 1);
      @(posedge clk); #1;
      chk("t1_start_latency", ser_tx, 0);
      chk("t1_level_after_pop", fifo_level, 0);
      repeat (39) @(posedge clk);
      #1;
      chk("t1_last_stop_busy", busy, 1);
      chk("t1_last_stop_ser", ser_tx, 1);
      @(posedge clk); #1;
      chk("t1_busy_fall", busy, 0);
      chk("t1_rx_byte", rx_at(0), 8'h55);

      // Table vectors: various divisors including 0/1 clamping
      for (int i = 0; i < 6; i++) begin
         repeat (2) @(posedge clk);
         #1;
         clk_div = vecs[i].div;
         mon_div = vecs[i].div_eff;
         clear_rx();
         push(vecs[i].data);
         chk($sformatf("vec%0d_level", i), fifo_level, vecs[i].exp_level);
         wait_rx(1, 10 * vecs[i].div_eff + 20);
         chk($sformatf("vec%0d_byte", i), rx_at(0), vecs[i].data);
         repeat (3) @(posedge clk);
         #1;
         chk($sformatf("vec%0d_busy_idle", i), busy, 0);
         chk($sformatf("vec%0d_ser_idle", i), ser_tx, 1);
      end

      // Test 2: back-to-back "AB\n" at div 3 with no idle gaps
      clk_div = 16'd3;
      mon_div = 3;
      clear_rx();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("t2_ready%0d", i), tx_ready, 1);
         push(msg[i]);
      end
      chk("t2_ready_after", tx_ready, 1);
      wait_rx(3, 200);
      for (int i = 0; i < 3; i++) chk($sformatf("t2_byte%0d", i), rx_at(i), msg[i]);
      chk("t2_gap1", gap_at(1), 0);
      chk("t2_gap2", gap_at(2), 0);

      // Test 3: FIFO full with tx_en=0, 5th byte dropped, ready rises after first pop
      repeat (5) @(posedge clk);
      #1;
      clk_div = 16'd2;
      mon_div = 2;
      tx_en   = 1'b0;
      clear_rx();
      for (int i = 0; i < 5; i++) push(8'(8'h11 * (i + 1)));
      chk("t3_level_full", fifo_level, 4);
      chk("t3_ready_full", tx_ready, 0);
      chk("t3_ser_held", ser_tx, 1);
      chk("t3_busy_queued", busy, 1);
      tx_en = 1'b1;
      chk("t3_ready_same_cycle", tx_ready, 0);
      @(posedge clk); #1;
      chk("t3_ready_after_pop", tx_ready, 1);
      chk("t3_level_after_pop", fifo_level, 3);
      wait_rx(4, 200);
      for (int i = 0; i < 4; i++) chk($sformatf("t3_byte%0d", i), rx_at(i), 8'h11 * (i + 1));
      for (int i = 1; i < 4; i++) chk($sformatf("t3_gap%0d", i), gap_at(i), 0);
      repeat (30) @(posedge clk);
      #1;
      chk("t3_dropped_fifth", rx_q.size(), 4);

      // Test 4: reset during d[3] of 0xA5 with another byte queued
      clk_div = 16'd4;
      mon_div = 4;
      clear_rx();
      push(8'hA5);
      push(8'h77);
      repeat (17) @(posedge clk);
      #1;
      chk("t4_in_d3", ser_tx, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t4_rst_ser", ser_tx, 1);
      chk("t4_rst_level", fifo_level, 0);
      chk("t4_rst_busy", busy, 0);
      chk("t4_rst_ready", tx_ready, 1);
      repeat (45) @(posedge clk);
      #1;
      chk("t4_no_frame", rx_q.size(), 0);
      chk("t4_line_idle", ser_tx, 1);
      push(8'h3C);
      wait_rx(1, 80);
      chk("t4_clean_byte", rx_at(0), 8'h3C);

      // Test 5: clk_div 4 -> 8 mid-frame
      repeat (3) @(posedge clk);
      #1;
      clear_rx();
      push(8'h96);
      push(8'h69);
      repeat (10) @(posedge clk);
      #1;
      clk_div = 16'd8;
      mon_div = 8;
      wait_rx(2, 300);
      chk("t5_byte0", rx_at(0), 8'h96);
      chk("t5_byte1", rx_at(1), 8'h69);
      chk("t5_gap1", gap_at(1), 0);

      // Test 6: tx_en dropped during DATA with 2 bytes queued
      repeat (3) @(posedge clk);
      #1;
      clk_div = 16'd2;
      mon_div = 2;
      tx_en   = 1'b0;
      clear_rx();
      push(8'hC3);
      push(8'h5A);
      push(8'hE7);
      tx_en = 1'b1;
      @(posedge clk); #1;
      chk("t6_level_after_pop", fifo_level, 2);
      repeat (5) @(posedge clk);
      #1;
      tx_en = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      chk("t6_one_frame", rx_q.size(), 1);
      chk("t6_byte0", rx_at(0), 8'hC3);
      chk("t6_level_held", fifo_level, 2);
      chk("t6_ser_high", ser_tx, 1);
      chk("t6_busy_held", busy, 1);
      tx_en = 1'b1;
      wait_rx(3, 100);
      chk("t6_byte1", rx_at(1), 8'h5A);
      chk("t6_byte2", rx_at(2), 8'hE7);
      repeat (4) @(posedge clk);
      #1;
      chk("t6_final_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
